// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared state encoding and default sizing for the render pipeline
package render_pkg;

    // Sequencer phases; the clear and draw engines decode these as well.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_DONE  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DRAW  = 2'd3
    } render_state_t;

    localparam int DEF_NUM_PASSES = 4;
    localparam int DEF_COORD_W    = 10;
    localparam int DEF_COLOR_W    = 24;
    localparam int DEF_TIMEOUT_W  = 20;
    localparam int DEF_OVR_W      = 8;

    // Width of a pass index; a single pass still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// rtl/frame_edge_detect.sv - two-flop frame tick synchroniser with registered rising-edge pulse
//
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_frame_clk   - frame tick from the display timing block
//   o_rise        - one-cycle registered pulse, f1 & ~f2
module frame_edge_detect
    import render_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_frame_clk,
    output logic o_rise
);

    logic r_f1;
    logic r_f2;
    logic r_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f1   <= 1'b0;
            r_f2   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_f1   <= i_frame_clk;
            r_f2   <= r_f1;
            r_rise <= r_f1 & ~r_f2;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - frame sequencer: load, clear, then enabled draw passes in ascending order
//
// Ports:
//   i_clk, i_rst                      - clock, asynchronous active-high reset
//   i_frame_clk                       - frame tick
//   i_load_done, i_clear_done         - phase completion from load / clear engines
//   i_clear_drawx/drawy               - clear-engine pixel address
//   i_draw_done                       - per-pass completion
//   i_draw_drawx/drawy/color          - per-pass pixel address and colour, pass p at slice p
//   i_pass_enable                     - passes to run in the next frame
//   i_err_clr                         - clears the sticky timeout error
//   o_load_obj/clear_start/proj_start - phase strobes (level)
//   o_draw_start                      - one-hot strobe for the active pass
//   o_drawx/drawy/draw_data           - muxed framebuffer write port
//   o_pass_idx                        - active pass index
//   o_frame_clk_rising_edge           - registered frame tick edge
//   o_frame_done, o_timeout_err       - idle indicator, sticky watchdog error
//   o_overrun_count                   - saturating count of frame ticks lost mid-frame
module render_sequencer
    import render_pkg::*;
#(
    parameter int  NUM_PASSES = DEF_NUM_PASSES,
    parameter int  COORD_W    = DEF_COORD_W,
    parameter int  COLOR_W    = DEF_COLOR_W,
    parameter int  TIMEOUT_W  = DEF_TIMEOUT_W,
    parameter int  OVR_W      = DEF_OVR_W,
    localparam int IDX_W      = idx_width(NUM_PASSES)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_frame_clk,
    input  logic                          i_load_done,
    input  logic                          i_clear_done,
    input  logic [COORD_W-1:0]            i_clear_drawx,
    input  logic [COORD_W-1:0]            i_clear_drawy,
    input  logic [NUM_PASSES-1:0]         i_draw_done,
    input  logic [NUM_PASSES*COORD_W-1:0] i_draw_drawx,
    input  logic [NUM_PASSES*COORD_W-1:0] i_draw_drawy,
    input  logic [NUM_PASSES*COLOR_W-1:0] i_draw_color,
    input  logic [NUM_PASSES-1:0]         i_pass_enable,
    input  logic                          i_err_clr,
    output logic                          o_load_obj,
    output logic                          o_clear_start,
    output logic                          o_proj_start,
    output logic [NUM_PASSES-1:0]         o_draw_start,
    output logic [COLOR_W-1:0]            o_draw_data,
    output logic [COORD_W-1:0]            o_drawx,
    output logic [COORD_W-1:0]            o_drawy,
    output logic [IDX_W-1:0]              o_pass_idx,
    output logic                          o_frame_clk_rising_edge,
    output logic                          o_frame_done,
    output logic                          o_timeout_err,
    output logic [OVR_W-1:0]              o_overrun_count
);

    // The watchdog fires on the cycle whose increment would make it all-ones,
    // so a stuck phase lasts exactly 2**TIMEOUT_W - 1 cycles.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = ~(TIMEOUT_W'(1));
    localparam logic [OVR_W-1:0]     OVR_MAX = '1;

    render_state_t             r_state;
    render_state_t             w_state_nxt;
    logic [NUM_PASSES-1:0]     r_pass_mask;
    logic [NUM_PASSES-1:0]     w_mask_nxt;
    logic [IDX_W-1:0]          r_pass_idx;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [TIMEOUT_W-1:0]      r_wd;
    logic                      r_timeout_err;
    logic [OVR_W-1:0]          r_ovr;

    logic                      w_frame_rise;
    logic                      w_busy;
    logic                      w_wd_expire;
    logic                      w_timeout_set;
    logic                      w_first_vld;
    logic [IDX_W-1:0]          w_first_idx;
    logic                      w_next_vld;
    logic [IDX_W-1:0]          w_next_idx;
    logic                      w_cur_done;
    logic [NUM_PASSES-1:0]     w_cur_onehot;
    logic [COORD_W-1:0]        w_cur_x;
    logic [COORD_W-1:0]        w_cur_y;
    logic [COLOR_W-1:0]        w_cur_color;

    frame_edge_detect u_edge (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_frame_clk (i_frame_clk),
        .o_rise      (w_frame_rise)
    );

    assign w_busy      = (r_state == ST_CLEAR) || (r_state == ST_DRAW);
    assign w_wd_expire = w_busy && (r_wd == WD_LAST);

    // Priority pass selection: lowest enabled pass, and the next enabled pass above the current one.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int p = NUM_PASSES - 1; p >= 0; p--) begin
            if (r_pass_mask[p]) begin
                w_first_vld = 1'b1;
                w_first_idx = IDX_W'(p);
                if (p > int'(r_pass_idx)) begin
                    w_next_vld = 1'b1;
                    w_next_idx = IDX_W'(p);
                end
            end
        end
    end

    // Slice mux for the active pass.
    always_comb begin
        w_cur_done   = 1'b0;
        w_cur_onehot = '0;
        w_cur_x      = '0;
        w_cur_y      = '0;
        w_cur_color  = '0;
        for (int p = 0; p < NUM_PASSES; p++) begin
            if (int'(r_pass_idx) == p) begin
                w_cur_done      = i_draw_done[p];
                w_cur_onehot[p] = 1'b1;
                w_cur_x         = i_draw_drawx[p*COORD_W +: COORD_W];
                w_cur_y         = i_draw_drawy[p*COORD_W +: COORD_W];
                w_cur_color     = i_draw_color[p*COLOR_W +: COLOR_W];
            end
        end
    end

    // Next-state and outputs. Completion is tested before the watchdog so that
    // a done arriving on the expiry cycle still advances normally.
    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_pass_mask;
        w_idx_nxt     = r_pass_idx;
        w_timeout_set = 1'b0;
        o_load_obj    = 1'b0;
        o_frame_done  = 1'b0;
        o_clear_start = 1'b0;
        o_proj_start  = 1'b0;
        o_draw_start  = '0;
        o_drawx       = '0;
        o_drawy       = '0;
        o_draw_data   = '0;
        case (r_state)
            ST_INIT: begin
                o_load_obj = 1'b1;
                if (i_load_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                if (w_frame_rise) begin
                    w_mask_nxt  = i_pass_enable;
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_clear_start = 1'b1;
                o_proj_start  = 1'b1;
                o_drawx       = i_clear_drawx;
                o_drawy       = i_clear_drawy;
                if (i_clear_done) begin
                    if (w_first_vld) begin
                        w_state_nxt = ST_DRAW;
                        w_idx_nxt   = w_first_idx;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_set = 1'b1;
                end
            end
            ST_DRAW: begin
                o_draw_start = w_cur_onehot;
                o_drawx      = w_cur_x;
                o_drawy      = w_cur_y;
                o_draw_data  = w_cur_color;
                if (w_cur_done) begin
                    if (w_next_vld) begin
                        w_idx_nxt = w_next_idx;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_wd_expire) begin
                    w_state_nxt   = ST_DONE;
                    w_timeout_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pass_mask   <= '0;
            r_pass_idx    <= '0;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
            r_ovr         <= '0;
        end else begin
            r_pass_mask <= w_mask_nxt;
            r_pass_idx  <= w_idx_nxt;

            if ((w_state_nxt != r_state) || (w_idx_nxt != r_pass_idx)) begin
                r_wd <= '0;
            end else if (w_busy) begin
                r_wd <= r_wd + 1'b1;
            end

            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end

            // A frame tick while a frame is still in flight is dropped and counted.
            if (w_frame_rise && w_busy && (r_ovr != OVR_MAX)) begin
                r_ovr <= r_ovr + 1'b1;
            end
        end
    end

    assign o_pass_idx              = r_pass_idx;
    assign o_frame_clk_rising_edge = w_frame_rise;
    assign o_timeout_err           = r_timeout_err;
    assign o_overrun_count         = r_ovr;

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 Parameter NUM_PASSES, default 4: number of draw passes (draw sources); legal range 1..16.
REQ-002 Parameter COORD_W, default 10: width of pixel coordinates.
REQ-003 Parameter COLOR_W, default 24: width of pixel colour.
REQ-004 Parameter TIMEOUT_W, default 20: width of the per-phase watchdog counter.
REQ-005 Parameter OVR_W, default 8: width of the overrun counter.
REQ-006 Clk  in  1  single clock; all state updates on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 frame_clk  in  1  frame tick from the display timing block.
REQ-009 load_done  in  1  object load complete.
REQ-010 clear_done  in  1  frame clear complete.
REQ-011 clear_DrawX, clear_DrawY  in  COORD_W each  clear-engine pixel address.
REQ-012 draw_done  in  NUM_PASSES  per-pass draw complete.
REQ-013 draw_DrawX, draw_DrawY  in  NUM_PASSES*COORD_W each  per-pass pixel address, pass p at slice p.
REQ-014 draw_color  in  NUM_PASSES*COLOR_W  per-pass colour, pass p at slice p.
REQ-015 pass_enable  in  NUM_PASSES  passes to run in the next frame.
REQ-016 err_clr  in  1  clears timeout_err.
REQ-017 load_obj, clear_start, proj_start  out  1 each  phase strobes (level).
REQ-018 draw_start  out  NUM_PASSES  one-hot level strobe for the active pass.
REQ-019 draw_data  out  COLOR_W; DrawX, DrawY  out  COORD_W each  muxed framebuffer write port.
REQ-020 pass_idx  out  $clog2(NUM_PASSES) (min 1)  active pass index.
REQ-021 frame_clk_rising_edge, frame_done, timeout_err  out  1 each; overrun_count  out  OVR_W.

Function
REQ-022 States: INIT, DONE, CLEAR, DRAW.
REQ-023 frame_clk is registered twice (f1, f2); frame_clk_rising_edge is a registered one-cycle pulse of f1 & ~f2.
REQ-024 INIT: load_obj=1; load_done -> DONE next cycle.
REQ-025 DONE: frame_done=1; frame_clk_rising_edge -> latch pass_enable into pass_mask, enter CLEAR.
REQ-026 CLEAR: clear_start=1, proj_start=1, DrawX/DrawY=clear coordinates, draw_data=0.
REQ-027 CLEAR with clear_done: pass_mask nonzero -> DRAW with pass_idx = lowest set bit; pass_mask zero -> DONE.
REQ-028 DRAW: draw_start[pass_idx]=1, other draw_start bits 0; DrawX/DrawY/draw_data=slice pass_idx.
REQ-029 DRAW with draw_done[pass_idx]: the next higher set bit of pass_mask becomes pass_idx (stay in DRAW); none -> DONE; draw_done of inactive passes ignored.
REQ-030 Outside CLEAR/DRAW, DrawX, DrawY, draw_data are 0; strobes not listed for a state are 0.
REQ-031 Watchdog: cleared on every state or pass_idx change, increments each cycle in CLEAR/DRAW; reaching all-ones sets timeout_err and forces DONE, abandoning the frame.
REQ-032 Done and watchdog expiry in the same cycle: done wins, timeout_err not set.
REQ-033 timeout_err is sticky; err_clr clears it; set and err_clr in the same cycle: set wins.
REQ-034 frame_clk_rising_edge in CLEAR or DRAW: edge ignored, overrun_count increments, saturating at all-ones; edges in INIT are ignored and not counted.
REQ-035 pass_enable changes mid-frame do not affect the current frame.

Reset
REQ-036 Reset asynchronously forces INIT, pass_mask=0, pass_idx=0, watchdog=0, f1=f2=0, frame_clk_rising_edge=0, timeout_err=0, overrun_count=0; load_obj=1 during reset; all other outputs 0.
REQ-037 Reset asserted mid-frame abandons the frame with no further strobes; sequencing restarts from INIT.

Structure
REQ-038 Package render_pkg holds the state enum and default parameter constants shared with the clear and draw engines.
REQ-039 Sub-module frame_edge_detect holds the f1/f2 registers and edge pulse; the priority pass selector stays inline.

Verification
REQ-040 Reset, load_done after 5 cycles -> load_obj 1 until load_done, then frame_done=1, all counters 0.
REQ-041 pass_enable=4'b1010, frame edge -> CLEAR, then DRAW pass 1, then pass 3, then DONE; DrawX/DrawY/draw_data track the active slice.
REQ-042 pass_enable=0 -> CLEAR then directly DONE; draw_start never asserted.
REQ-043 TIMEOUT_W=4, clear_done withheld -> timeout_err=1 after 15 CLEAR cycles, DONE; err_clr -> 0.
REQ-044 Three frame edges during DRAW -> overrun_count=3, pass sequence unaffected; OVR_W=2 with 5 edges -> saturates at 3.
REQ-045 Reset asserted mid-DRAW -> all strobes drop asynchronously; state INIT, counters 0.
